booth_mul_seq: RTL

- Multi-cycle signed 32x32 -> 64-bit multiplier using radix-2 Booth recoding. It sits directly downstream of the 32-bit carry-lookahead adder.
- Each Booth step adds or subtracts the multiplicand into the upper partial-product accumulator, then arithmetic-shifts.
- The 64-bit product goes out as z_hi/z_lo for the datapath's ZHigh/ZLow registers. A start/busy/done handshake lets the control unit stall for the MUL instruction.

---
 rtl/booth_mul_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - multi-cycle signed radix-2 Booth multiplier, DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH
//
// Ports:
//   clock        rising-edge clock
//   clear        synchronous active-low reset
//   start        operation request, sampled only in IDLE
//   a, b         multiplicand / multiplier (two's complement), captured on accepted start
//   busy         high while Booth steps execute
//   done         one-cycle pulse when z_hi/z_lo have just been updated
//   z_hi, z_lo   upper / lower halves of the last completed product
//   ovf          (only with BOOTH_MUL_OVF_EN) product does not fit in DATA_WIDTH signed bits
//
// Optional feature macro: BOOTH_MUL_OVF_EN

module booth_mul_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] z_hi,
`ifdef BOOTH_MUL_OVF_EN
    output logic [DATA_WIDTH-1:0] z_lo,
    output logic                  ovf
`else
    output logic [DATA_WIDTH-1:0] z_lo
`endif
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] m;
    // Accumulator is one bit wider so subtracting the most negative multiplicand cannot overflow.
    logic [DATA_WIDTH:0]   acc;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_m1;
    logic [CW-1:0]         count;

    logic [DATA_WIDTH:0]   m_ext;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   acc_sh;
    logic [DATA_WIDTH-1:0] q_sh;
    logic                  last_step;

    // One Booth step: conditional add/subtract, then arithmetic shift of {acc, q, q_m1}.
    always_comb begin
        m_ext = {m[DATA_WIDTH-1], m};
        sum   = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + m_ext;
            2'b10:   sum = acc - m_ext;
            default: sum = acc;
        endcase
        acc_sh    = {sum[DATA_WIDTH], sum[DATA_WIDTH:1]};
        q_sh      = {sum[0], q[DATA_WIDTH-1:1]};
        last_step = (count == CW'(DATA_WIDTH - 1));
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            z_hi  <= '0;
            z_lo  <= '0;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            count <= '0;
`ifdef BOOTH_MUL_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= a;
                        q     <= b;
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= acc_sh;
                    q     <= q_sh;
                    q_m1  <= q[0];
                    count <= count + 1'b1;
                    if (last_step) begin
                        // Product lives in the low DATA_WIDTH bits of acc plus q after the final shift.
                        z_hi  <= acc_sh[DATA_WIDTH-1:0];
                        z_lo  <= q_sh;
`ifdef BOOTH_MUL_OVF_EN
                        ovf   <= (acc_sh[DATA_WIDTH-1:0] != {DATA_WIDTH{q_sh[DATA_WIDTH-1]}});
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Start is deliberately not sampled here; it is only honoured from IDLE.
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
